// File: rtl/pe_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : pe_stream_feeder
//  Description : NUM_CH independent valid/ready burst sources that emit
//                segments of incrementing (optionally negated) values for
//                the PE fmap / weight / psum load ports.
//  Revision    : 1.0  initial release
// ============================================================================
module pe_stream_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 3,
    parameter int LEN_WIDTH  = 8,
    parameter int SEG_WIDTH  = 4,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              start_i,
    input  logic [NUM_CH-1:0]              abort_i,
    input  logic [NUM_CH-1:0]              sync_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   cfg_base_i,
    input  logic [NUM_CH*LEN_WIDTH-1:0]    cfg_len_i,
    input  logic [NUM_CH*SEG_WIDTH-1:0]    cfg_seg_i,
    input  logic [NUM_CH*GAP_WIDTH-1:0]    cfg_gap_i,
    input  logic [NUM_CH-1:0]              cfg_neg_i,
    input  logic [NUM_CH-1:0]              cfg_sync_i,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_data_o,
    output logic [NUM_CH-1:0]              out_valid_o,
    input  logic [NUM_CH-1:0]              out_ready_i,
    output logic [NUM_CH-1:0]              busy_o,
    output logic [NUM_CH-1:0]              done_o,
    output logic                           all_done_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BURST     = 3'd1,
        S_GAP       = 3'd2,
        S_WAIT_SYNC = 3'd3,
        S_FIN       = 3'd4
    } state_t;

    logic [NUM_CH-1:0] fin;
    logic [NUM_CH-1:0] busy;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t                 state_q,  state_d;
        logic [DATA_WIDTH-1:0]  value_q,  value_d;
        logic [DATA_WIDTH-1:0]  data_q,   data_d;
        logic [LEN_WIDTH-1:0]   len_q,    len_d;
        logic [LEN_WIDTH-1:0]   beat_q,   beat_d;
        logic [SEG_WIDTH-1:0]   nseg_q,   nseg_d;
        logic [SEG_WIDTH-1:0]   seg_q,    seg_d;
        logic [GAP_WIDTH-1:0]   gap_q,    gap_d;
        logic [GAP_WIDTH-1:0]   gapcnt_q, gapcnt_d;
        logic                   neg_q,    neg_d;
        logic                   syncen_q, syncen_d;
        logic                   flag_q,   flag_d;
        logic                   valid_q,  valid_d;
        logic                   fire;
        logic                   sync_hit;

        always_comb begin
            state_d  = state_q;
            value_d  = value_q;
            len_d    = len_q;
            beat_d   = beat_q;
            nseg_d   = nseg_q;
            seg_d    = seg_q;
            gap_d    = gap_q;
            gapcnt_d = gapcnt_q;
            neg_d    = neg_q;
            syncen_d = syncen_q;
            flag_d   = flag_q;
            fire     = valid_q & out_ready_i[g];
            sync_hit = flag_q | sync_i[g];

            if (state_q != S_IDLE && sync_i[g]) begin
                flag_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i[g]) begin
                        value_d  = cfg_base_i[g*DATA_WIDTH +: DATA_WIDTH];
                        len_d    = cfg_len_i[g*LEN_WIDTH +: LEN_WIDTH];
                        nseg_d   = cfg_seg_i[g*SEG_WIDTH +: SEG_WIDTH];
                        gap_d    = cfg_gap_i[g*GAP_WIDTH +: GAP_WIDTH];
                        neg_d    = cfg_neg_i[g];
                        syncen_d = cfg_sync_i[g];
                        seg_d    = '0;
                        beat_d   = '0;
                        flag_d   = 1'b0;
                        // Empty segments carry no beats, so the whole run collapses to FIN.
                        if (nseg_d == '0 || len_d == '0) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (fire) begin
                        value_d = value_q + DATA_WIDTH'(1);
                        if (beat_q == len_q - LEN_WIDTH'(1)) begin
                            beat_d = '0;
                            if (seg_q == nseg_q - SEG_WIDTH'(1)) begin
                                state_d = S_FIN;
                            end else begin
                                seg_d = seg_q + SEG_WIDTH'(1);
                                if (gap_q != '0) begin
                                    state_d  = S_GAP;
                                    gapcnt_d = gap_q;
                                end else if (syncen_q && !sync_hit) begin
                                    state_d = S_WAIT_SYNC;
                                end else begin
                                    state_d = S_BURST;
                                    if (syncen_q) begin
                                        flag_d = 1'b0;
                                    end
                                end
                            end
                        end else begin
                            beat_d = beat_q + LEN_WIDTH'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gapcnt_q == GAP_WIDTH'(1)) begin
                        if (syncen_q && !sync_hit) begin
                            state_d = S_WAIT_SYNC;
                        end else begin
                            state_d = S_BURST;
                            if (syncen_q) begin
                                flag_d = 1'b0;
                            end
                        end
                    end else begin
                        gapcnt_d = gapcnt_q - GAP_WIDTH'(1);
                    end
                end
                S_WAIT_SYNC: begin
                    if (sync_hit) begin
                        state_d = S_BURST;
                        flag_d  = 1'b0;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (abort_i[g]) begin
                state_d = S_IDLE;
                flag_d  = 1'b0;
            end

            // Output word is built from the next-state value so it is a plain register.
            valid_d = (state_d == S_BURST);
            data_d  = neg_d ? (~value_d + DATA_WIDTH'(1)) : value_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= S_IDLE;
                value_q  <= '0;
                data_q   <= '0;
                len_q    <= '0;
                beat_q   <= '0;
                nseg_q   <= '0;
                seg_q    <= '0;
                gap_q    <= '0;
                gapcnt_q <= '0;
                neg_q    <= 1'b0;
                syncen_q <= 1'b0;
                flag_q   <= 1'b0;
                valid_q  <= 1'b0;
            end else begin
                state_q  <= state_d;
                value_q  <= value_d;
                data_q   <= data_d;
                len_q    <= len_d;
                beat_q   <= beat_d;
                nseg_q   <= nseg_d;
                seg_q    <= seg_d;
                gap_q    <= gap_d;
                gapcnt_q <= gapcnt_d;
                neg_q    <= neg_d;
                syncen_q <= syncen_d;
                flag_q   <= flag_d;
                valid_q  <= valid_d;
            end
        end

        assign out_data_o[g*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign out_valid_o[g] = valid_q;
        assign busy[g]        = (state_q != S_IDLE);
        assign fin[g]         = (state_q == S_FIN);
    end

    assign busy_o     = busy;
    assign done_o     = fin;
    // Fires with the done that leaves every channel idle.
    assign all_done_o = (|fin) && ((busy & ~fin) == '0);

endmodule
`default_nettype wire

// File: tb/tb_pe_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_stream_feeder
//  Description : Directed self-checking bench for pe_stream_feeder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_stream_feeder;

    localparam int DW = 16;
    localparam int NC = 3;
    localparam int LW = 8;
    localparam int SW = 4;
    localparam int GW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     start, abort, sync, cfg_neg, cfg_sync, out_ready;
    logic [NC*DW-1:0]  cfg_base;
    logic [NC*LW-1:0]  cfg_len;
    logic [NC*SW-1:0]  cfg_seg;
    logic [NC*GW-1:0]  cfg_gap;
    logic [NC*DW-1:0]  out_data;
    logic [NC-1:0]     out_valid, busy, done;
    logic              all_done;

    int n_cmp = 0;
    int n_err = 0;

    wire [DW-1:0] d0 = out_data[0*DW +: DW];
    wire [DW-1:0] d1 = out_data[1*DW +: DW];
    wire [DW-1:0] d2 = out_data[2*DW +: DW];

    always #5 clk = ~clk;

    pe_stream_feeder #(
        .DATA_WIDTH(DW), .NUM_CH(NC), .LEN_WIDTH(LW), .SEG_WIDTH(SW), .GAP_WIDTH(GW)
    ) dut (
        .clk(clk), .rst(rst),
        .start_i(start), .abort_i(abort), .sync_i(sync),
        .cfg_base_i(cfg_base), .cfg_len_i(cfg_len), .cfg_seg_i(cfg_seg),
        .cfg_gap_i(cfg_gap), .cfg_neg_i(cfg_neg), .cfg_sync_i(cfg_sync),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .busy_o(busy), .done_o(done), .all_done_o(all_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input logic [DW-1:0] base, input logic [LW-1:0] len,
                           input logic [SW-1:0] seg, input logic [GW-1:0] gap,
                           input logic neg, input logic sy);
        cfg_base[ch*DW +: DW] = base;
        cfg_len[ch*LW +: LW]  = len;
        cfg_seg[ch*SW +: SW]  = seg;
        cfg_gap[ch*GW +: GW]  = gap;
        cfg_neg[ch]           = neg;
        cfg_sync[ch]          = sy;
    endtask

    task automatic pulse_start(input logic [NC-1:0] m);
        start = m;
        step();
        start = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_cmp++;
        if (out_valid !== '0 || busy !== '0 || done !== '0 || all_done !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset valid=%b busy=%b done=%b all=%b data=%h required all zero",
                     out_valid, busy, done, all_done, out_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_neg_gap();
        logic [DW-1:0] e;
        set_cfg(0, 16'd1, 8'd6, 4'd2, 8'd20, 1'b1, 1'b0);
        pulse_start(3'b001);
        for (int k = 1; k <= 12; k++) begin
            if (k == 7) begin
                for (int c = 0; c < 20; c++) begin
                    n_cmp++;
                    if (out_valid[0] !== 1'b0) begin
                        n_err++;
                        $display("FAIL neg_gap idle cycle %0d valid=%b required 0", c, out_valid[0]);
                    end
                    step();
                end
            end
            e = DW'(-k);
            n_cmp++;
            if (out_valid[0] !== 1'b1 || d0 !== e) begin
                n_err++;
                $display("FAIL neg_gap beat %0d valid=%b data=%h required valid=1 data=%h", k, out_valid[0], d0, e);
            end
            step();
        end
        n_cmp++;
        if (done[0] !== 1'b1 || all_done !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL neg_gap done done=%b all=%b valid=%b required 1 1 0", done[0], all_done, out_valid[0]);
        end
        step();
        n_cmp++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL neg_gap idle done=%b busy=%b required 0 0", done[0], busy[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] v;
        logic rdy;
        int cyc;
        set_cfg(1, 16'd1, 8'd9, 4'd1, 8'd0, 1'b0, 1'b0);
        pulse_start(3'b010);
        v = 16'd1;
        cyc = 0;
        while (v <= 16'd9 && cyc < 40) begin
            n_cmp++;
            if (out_valid[1] !== 1'b1 || d1 !== v) begin
                n_err++;
                $display("FAIL backpressure cyc %0d valid=%b data=%h required valid=1 data=%h", cyc, out_valid[1], d1, v);
            end
            out_ready[1] = (cyc % 2 == 0);
            rdy = out_ready[1];
            step();
            cyc++;
            if (rdy) v = v + 16'd1;
        end
        out_ready[1] = 1'b1;
        n_cmp++;
        if (cyc >= 40 || done[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure end cyc=%0d done=%b valid=%b required done=1 valid=0", cyc, done[1], out_valid[1]);
        end
        step();
    endtask

    task automatic test_sync();
        logic [DW-1:0] e;
        set_cfg(0, 16'd1, 8'd12, 4'd3, 8'd0, 1'b0, 1'b1);
        pulse_start(3'b001);
        for (int k = 1; k <= 36; k++) begin
            if (k == 25) begin
                for (int c = 0; c < 80; c++) begin
                    n_cmp++;
                    if (out_valid[0] !== 1'b0) begin
                        n_err++;
                        $display("FAIL sync wait cycle %0d valid=%b required 0", c, out_valid[0]);
                    end
                    if (c == 79) sync[0] = 1'b1;
                    step();
                    sync[0] = 1'b0;
                end
            end
            e = DW'(k);
            n_cmp++;
            if (out_valid[0] !== 1'b1 || d0 !== e) begin
                n_err++;
                $display("FAIL sync beat %0d valid=%b data=%h required valid=1 data=%h", k, out_valid[0], d0, e);
            end
            sync[0] = (k == 3);
            step();
            sync[0] = 1'b0;
        end
        n_cmp++;
        if (done[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sync done done=%b required 1", done[0]);
        end
        step();
    endtask

    task automatic test_zero_len();
        set_cfg(2, 16'd7, 8'd0, 4'd2, 8'd0, 1'b0, 1'b0);
        pulse_start(3'b100);
        n_cmp++;
        if (done[2] !== 1'b1 || out_valid[2] !== 1'b0 || all_done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_len done=%b valid=%b all=%b required 1 0 1", done[2], out_valid[2], all_done);
        end
        step();
        n_cmp++;
        if (busy[2] !== 1'b0 || done[2] !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len idle busy=%b done=%b required 0 0", busy[2], done[2]);
        end
        set_cfg(2, 16'd7, 8'd5, 4'd0, 8'd0, 1'b0, 1'b0);
        pulse_start(3'b100);
        n_cmp++;
        if (done[2] !== 1'b1 || out_valid[2] !== 1'b0) begin
            n_err++;
            $display("FAIL zero_seg done=%b valid=%b required 1 0", done[2], out_valid[2]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        set_cfg(2, 16'd10, 8'd3, 4'd3, 8'd0, 1'b0, 1'b0);
        pulse_start(3'b100);
        for (int k = 0; k < 9; k++) begin
            e = DW'(10 + k);
            n_cmp++;
            if (out_valid[2] !== 1'b1 || d2 !== e) begin
                n_err++;
                $display("FAIL back_to_back beat %0d valid=%b data=%h required valid=1 data=%h", k, out_valid[2], d2, e);
            end
            step();
        end
        n_cmp++;
        if (done[2] !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back done=%b required 1", done[2]);
        end
        step();
    endtask

    task automatic test_abort();
        logic [DW-1:0] e;
        logic ch1_done_seen;
        set_cfg(0, 16'd100, 8'd20, 4'd1, 8'd0, 1'b0, 1'b0);
        set_cfg(1, 16'd1, 8'd9, 4'd1, 8'd0, 1'b0, 1'b0);
        pulse_start(3'b011);
        ch1_done_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            e = DW'(99 + k);
            n_cmp++;
            if (out_valid[0] !== 1'b1 || d0 !== e) begin
                n_err++;
                $display("FAIL abort ch0 beat %0d valid=%b data=%h required valid=1 data=%h", k, out_valid[0], d0, e);
            end
            if (k == 6) begin
                n_cmp++;
                if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort ch1 valid=%b busy=%b required 0 0", out_valid[1], busy[1]);
                end
            end
            if (done[1] === 1'b1) ch1_done_seen = 1'b1;
            abort[1] = (k == 5);
            step();
            abort[1] = 1'b0;
        end
        n_cmp++;
        if (done[0] !== 1'b1 || all_done !== 1'b1 || done[1] !== 1'b0 || ch1_done_seen) begin
            n_err++;
            $display("FAIL abort end done=%b all=%b ch1_done_seen=%b required done=01 all=1 seen=0",
                     done[1:0], all_done, ch1_done_seen);
        end
        step();
    endtask

    task automatic test_rst_gap();
        set_cfg(0, 16'd1, 8'd6, 4'd2, 8'd20, 1'b0, 1'b0);
        pulse_start(3'b001);
        for (int c = 0; c < 9; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== '0 || busy !== '0 || done !== '0 || all_done !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL rst_gap valid=%b busy=%b done=%b all=%b data=%h required all zero",
                     out_valid, busy, done, all_done, out_data);
        end
        pulse_start(3'b001);
        n_cmp++;
        if (out_valid[0] !== 1'b1 || d0 !== 16'd1) begin
            n_err++;
            $display("FAIL rst_gap replay valid=%b data=%h required valid=1 data=0001", out_valid[0], d0);
        end
        step(); step();
        set_cfg(0, 16'd500, 8'd6, 4'd2, 8'd20, 1'b0, 1'b0);
        pulse_start(3'b001);
        n_cmp++;
        if (out_valid[0] !== 1'b1 || d0 !== 16'd4) begin
            n_err++;
            $display("FAIL start_busy valid=%b data=%h required valid=1 data=0004", out_valid[0], d0);
        end
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_ch0 busy=%b valid=%b done=%b required 0 0 0", busy[0], out_valid[0], done[0]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = '0;
        abort     = '0;
        sync      = '0;
        out_ready = '1;
        cfg_base  = '0;
        cfg_len   = '0;
        cfg_seg   = '0;
        cfg_gap   = '0;
        cfg_neg   = '0;
        cfg_sync  = '0;
        test_reset();
        test_neg_gap();
        test_backpressure();
        test_sync();
        test_zero_len();
        test_back_to_back();
        test_abort();
        test_rst_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
